// File: rtl/bcd_display_feeder_if.sv
// Load/result bundle between the count sources, bcd_display_feeder and dual_display_controller.
// Build macro OVERFLOW_FLAG_EN adds the per-number saturation flags.
interface bcd_display_feeder_if #(
   parameter int BIN_W = 14
) ();
   logic             load;
   logic [BIN_W-1:0] bin_A;
   logic [BIN_W-1:0] bin_B;
   logic [15:0]      digits_A;
   logic [15:0]      digits_B;
   logic             busy;
   logic             done;
`ifdef OVERFLOW_FLAG_EN
   logic             ovf_A;
   logic             ovf_B;

   modport master (output load, bin_A, bin_B,
                   input  digits_A, digits_B, busy, done, ovf_A, ovf_B);
   modport slave  (input  load, bin_A, bin_B,
                   output digits_A, digits_B, busy, done, ovf_A, ovf_B);
`else
   modport master (output load, bin_A, bin_B,
                   input  digits_A, digits_B, busy, done);
   modport slave  (input  load, bin_A, bin_B,
                   output digits_A, digits_B, busy, done);
`endif
endinterface

// File: rtl/bcd_display_feeder.sv
// Two parallel double-dabble engines feeding a 4+4 digit display; both words commit on one edge.
// Build macro OVERFLOW_FLAG_EN adds ovf_A/ovf_B saturation flags.
module bcd_display_feeder #(
   parameter int BIN_W   = 14,
   parameter int MAX_VAL = 9999
) (
   input logic                  clk,
   input logic                  rst_n,
   bcd_display_feeder_if.slave  bus
);

   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);
   localparam logic [BIN_W-1:0] SAT_MAX   = BIN_W'(MAX_VAL);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;

   function automatic logic [BIN_W-1:0] sat(input logic [BIN_W-1:0] v);
      return (v > SAT_MAX) ? SAT_MAX : v;
   endfunction

   function automatic logic [15:0] add3(input logic [15:0] v);
      logic [15:0] r;
      r = v;
      for (int i = 0; i < 4; i++) begin
         if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             pend;
   logic             busy_r, done_r;
   logic [15:0]      dig_a, dig_b;
   logic [15:0]      bcd_a, bcd_b;
   logic [BIN_W-1:0] sr_a, sr_b;
   logic [BIN_W-1:0] pbuf_a, pbuf_b;
   logic [15:0]      adj_a, adj_b;
   logic             start_new;

   assign adj_a = add3(bcd_a);
   assign adj_b = add3(bcd_b);
   // A COMMIT with a fresh load or a parked request rolls straight into a new conversion.
   assign start_new = bus.load || pend;

   assign bus.digits_A = dig_a;
   assign bus.digits_B = dig_b;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;

   // Control and visible outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         pend   <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         dig_a  <= 16'h0000;
         dig_b  <= 16'h0000;
      end else begin
         done_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.load) begin
                  state  <= ST_SHIFT;
                  cnt    <= '0;
                  busy_r <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (bus.load) pend <= 1'b1;
               if (cnt == LAST_ITER) state <= ST_COMMIT;
               else                  cnt   <= cnt + 1'b1;
            end
            ST_COMMIT: begin
               dig_a  <= bcd_a;
               dig_b  <= bcd_b;
               done_r <= 1'b1;
               pend   <= 1'b0;
               if (start_new) begin
                  state <= ST_SHIFT;
                  cnt   <= '0;
               end else begin
                  state  <= ST_IDLE;
                  busy_r <= 1'b0;
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   // Datapath: shift registers, accumulators and the pending buffer carry no reset
   always_ff @(posedge clk) begin
      case (state)
         ST_IDLE: begin
            if (bus.load) begin
               sr_a  <= sat(bus.bin_A);
               sr_b  <= sat(bus.bin_B);
               bcd_a <= 16'h0000;
               bcd_b <= 16'h0000;
            end
         end
         ST_SHIFT: begin
            bcd_a <= (adj_a << 1) | 16'(sr_a[BIN_W-1]);
            bcd_b <= (adj_b << 1) | 16'(sr_b[BIN_W-1]);
            sr_a  <= sr_a << 1;
            sr_b  <= sr_b << 1;
            if (bus.load) begin
               pbuf_a <= sat(bus.bin_A);
               pbuf_b <= sat(bus.bin_B);
            end
         end
         ST_COMMIT: begin
            if (bus.load) begin
               sr_a  <= sat(bus.bin_A);
               sr_b  <= sat(bus.bin_B);
               bcd_a <= 16'h0000;
               bcd_b <= 16'h0000;
            end else if (pend) begin
               sr_a  <= pbuf_a;
               sr_b  <= pbuf_b;
               bcd_a <= 16'h0000;
               bcd_b <= 16'h0000;
            end
         end
         default: ;
      endcase
   end

`ifdef OVERFLOW_FLAG_EN
   logic ovf_cap_a, ovf_cap_b, ovf_pend_a, ovf_pend_b;
   logic ovf_a_r, ovf_b_r;

   assign bus.ovf_A = ovf_a_r;
   assign bus.ovf_B = ovf_b_r;

   always_ff @(posedge clk) begin
      if (bus.load && (state == ST_IDLE || state == ST_COMMIT)) begin
         ovf_cap_a <= (bus.bin_A > SAT_MAX);
         ovf_cap_b <= (bus.bin_B > SAT_MAX);
      end else if (state == ST_COMMIT && pend) begin
         ovf_cap_a <= ovf_pend_a;
         ovf_cap_b <= ovf_pend_b;
      end
      if (bus.load && state == ST_SHIFT) begin
         ovf_pend_a <= (bus.bin_A > SAT_MAX);
         ovf_pend_b <= (bus.bin_B > SAT_MAX);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_a_r <= 1'b0;
         ovf_b_r <= 1'b0;
      end else if (state == ST_COMMIT) begin
         ovf_a_r <= ovf_cap_a;
         ovf_b_r <= ovf_cap_b;
      end
   end
`endif

endmodule

// File: tb/tb_bcd_display_feeder.sv
// Directed bench for bcd_display_feeder: latency, saturation, pending buffer and reset abort.
module tb_bcd_display_feeder;

   logic clk;
   logic rst_n;

   bcd_display_feeder_if #(.BIN_W(14)) bus ();

   bcd_display_feeder #(.BIN_W(14), .MAX_VAL(9999)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] busy_log [0:63];
   logic [31:0] done_log [0:63];
   logic [31:0] da_log   [0:63];
   logic [31:0] db_log   [0:63];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Logs samples #1 after edges 0..n; a load slot with k >= 0 drives load into edge k.
   task automatic watch(input int n,
                        input int k1, input int a1, input int b1,
                        input int k2, input int a2, input int b2,
                        input int k3, input int a3, input int b3);
      for (int k = 0; k <= n; k++) begin
         if (k == k1) begin bus.bin_A = 14'(a1); bus.bin_B = 14'(b1); bus.load = 1'b1; end
         if (k == k2) begin bus.bin_A = 14'(a2); bus.bin_B = 14'(b2); bus.load = 1'b1; end
         if (k == k3) begin bus.bin_A = 14'(a3); bus.bin_B = 14'(b3); bus.load = 1'b1; end
         @(posedge clk);
         #1;
         bus.load = 1'b0;
         busy_log[k] = 32'(bus.busy);
         done_log[k] = 32'(bus.done);
         da_log[k]   = 32'(bus.digits_A);
         db_log[k]   = 32'(bus.digits_B);
      end
   endtask

   function automatic int sum_log(input int which, input int n);
      int s = 0;
      for (int k = 0; k <= n; k++) s += (which == 0) ? int'(busy_log[k]) : int'(done_log[k]);
      return s;
   endfunction

   function automatic int first_done(input int n);
      for (int k = 0; k <= n; k++) if (done_log[k] == 32'd1) return k;
      return -1;
   endfunction

   function automatic int seen_a(input int n, input logic [31:0] v);
      int s = 0;
      for (int k = 0; k <= n; k++) if (da_log[k] == v) s++;
      return s;
   endfunction

   initial begin
      rst_n      = 1'b0;
      bus.load   = 1'b0;
      bus.bin_A  = '0;
      bus.bin_B  = '0;
      #12;
      chk("rst_digits_A", 32'(bus.digits_A), 'h0000);
      chk("rst_digits_B", 32'(bus.digits_B), 'h0000);
      chk("rst_busy",     32'(bus.busy), 0);
      chk("rst_done",     32'(bus.done), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Basic conversion and latency
      watch(20, 0, 1234, 5678, -1, 0, 0, -1, 0, 0);
      chk("t2_busy_cycles", 32'(sum_log(0, 20)), 15);
      chk("t2_first_done",  32'(first_done(20)), 15);
      chk("t2_done_count",  32'(sum_log(1, 20)), 1);
      chk("t2_A_before",    da_log[14], 'h0000);
      chk("t2_A",           da_log[15], 'h1234);
      chk("t2_B",           db_log[15], 'h5678);
      chk("t2_busy_after",  busy_log[15], 0);
      chk("t2_A_hold",      da_log[20], 'h1234);

      // Saturation
      watch(18, 0, 0, 12000, -1, 0, 0, -1, 0, 0);
      chk("t3_A",       da_log[15], 'h0000);
      chk("t3_B",       db_log[15], 'h9999);
`ifdef OVERFLOW_FLAG_EN
      chk("t3_ovf_A",   32'(bus.ovf_A), 0);
      chk("t3_ovf_B",   32'(bus.ovf_B), 1);
`endif
      watch(18, 0, 16383, 9, -1, 0, 0, -1, 0, 0);
      chk("t3b_A",      da_log[15], 'h9999);
      chk("t3b_B",      db_log[15], 'h0009);
`ifdef OVERFLOW_FLAG_EN
      chk("t3b_ovf_A",  32'(bus.ovf_A), 1);
      chk("t3b_ovf_B",  32'(bus.ovf_B), 0);
`endif

      // Pending buffer, last value wins
      watch(35, 0, 1234, 5678, 5, 42, 7, 8, 99, 100);
      chk("t4_A1",          da_log[15], 'h1234);
      chk("t4_B1",          db_log[15], 'h5678);
      chk("t4_busy_at_c1",  busy_log[15], 1);
      chk("t4_A1_hold",     da_log[29], 'h1234);
      chk("t4_A2",          da_log[30], 'h0099);
      chk("t4_B2",          db_log[30], 'h0100);
      chk("t4_done_count",  32'(sum_log(1, 35)), 2);
      chk("t4_busy_cycles", 32'(sum_log(0, 35)), 30);
      chk("t4_no_42",       32'(seen_a(35, 'h0042)), 0);

      // Load exactly in the COMMIT cycle
      watch(35, 0, 2468, 1357, 15, 9999, 1, -1, 0, 0);
      chk("t5_A1",          da_log[15], 'h2468);
      chk("t5_B1",          db_log[15], 'h1357);
      chk("t5_A2",          da_log[30], 'h9999);
      chk("t5_B2",          db_log[30], 'h0001);
      chk("t5_done_count",  32'(sum_log(1, 35)), 2);

      // Reset mid-conversion aborts it
      watch(7, 0, 1234, 5678, -1, 0, 0, -1, 0, 0);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6_async_A",     32'(bus.digits_A), 'h0000);
      chk("t6_async_B",     32'(bus.digits_B), 'h0000);
      chk("t6_async_busy",  32'(bus.busy), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      watch(20, -1, 0, 0, -1, 0, 0, -1, 0, 0);
      chk("t6_done_count",  32'(sum_log(1, 20)), 0);
      chk("t6_busy_cycles", 32'(sum_log(0, 20)), 0);
      chk("t6_A",           da_log[20], 'h0000);
      chk("t6_B",           db_log[20], 'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
